// File: rtl/l1_biu.sv
// l1_biu: executes L1 cache transfer requests (refill, writeback, single
// read, single write-through) over a single-beat req/ack memory bus with a
// per-beat timeout.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for a request from the L1 controller
// SINGLE   | one uncached read or write-through beat on the bus
// FILL_REQ | refill beat outstanding on the bus
// FILL_WR  | refill beat written into the cache SRAM (line_write)
// WB_RD    | cache SRAM read of the writeback beat at addr_count
// WB_REQ   | writeback beat outstanding on the bus
// DONE     | transfer complete, trans_rdy pulse
// ERR      | transfer aborted (mem_err or timeout), bus_error pulse
module l1_biu #(
  parameter int ADDR_WIDTH  = 24,
  parameter int DATA_WIDTH  = 8,
  parameter int LINE_BYTES  = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  read_req,
  input  logic                  read_line_req,
  input  logic                  write_through_req,
  input  logic                  write_line_req,
  input  logic [ADDR_WIDTH-1:0] pa,
  input  logic [DATA_WIDTH-1:0] wt_data,
  output logic [DATA_WIDTH-1:0] line_data,
  output logic [7:0]            addr_count,
  output logic                  line_write,
  output logic                  cache_entry_refill,
  output logic                  trans_rdy,
  output logic                  bus_error,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  input  logic                  mem_err
);

  localparam int OFS = $clog2(LINE_BYTES);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, SINGLE, FILL_REQ, FILL_WR, WB_RD, WB_REQ, DONE, ERR
  } state_t;

  state_t                     state, state_nx;
  logic [OFS-1:0]             cnt_q;
  logic [OFS-1:0]             cnt_inc;
  logic [7:0]                 tmo_cnt;
  logic [ADDR_WIDTH-OFS-1:0]  base_q;
  logic                       is_fill;
  logic                       last_beat;
  logic                       bus_ack;
  logic                       bus_err;
  logic                       bus_tmo;

  // Responses only count while a request is outstanding; error beats ack.
  assign bus_err   = mem_req & mem_err;
  assign bus_ack   = mem_req & mem_ack & ~mem_err;
  assign bus_tmo   = mem_req & ~mem_ack & ~mem_err & (tmo_cnt == TMO_LAST);
  assign last_beat = &cnt_q;
  assign cnt_inc   = cnt_q + 1'b1;

  assign addr_count         = 8'(cnt_q);
  assign line_write         = (state == FILL_WR);
  assign trans_rdy          = (state == DONE);
  assign cache_entry_refill = (state == DONE) & is_fill;
  assign bus_error          = (state == ERR);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode; line ops outrank single ops, writeback outranks refill.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (write_line_req)                      state_nx = WB_RD;
        else if (read_line_req)                  state_nx = FILL_REQ;
        else if (write_through_req || read_req)  state_nx = SINGLE;
      end
      SINGLE: begin
        if (bus_err || bus_tmo) state_nx = ERR;
        else if (bus_ack)       state_nx = DONE;
      end
      FILL_REQ: begin
        if (bus_err || bus_tmo) state_nx = ERR;
        else if (bus_ack)       state_nx = FILL_WR;
      end
      FILL_WR:  state_nx = last_beat ? DONE : FILL_REQ;
      WB_RD:    state_nx = WB_REQ;
      WB_REQ: begin
        if (bus_err || bus_tmo) state_nx = ERR;
        else if (bus_ack)       state_nx = last_beat ? DONE : WB_RD;
      end
      DONE:     state_nx = IDLE;
      ERR:      state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Bus request, beat counter, timeout counter and read-data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      line_data <= '0;
      cnt_q     <= '0;
      tmo_cnt   <= '0;
      base_q    <= '0;
      is_fill   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          cnt_q   <= '0;
          if (state_nx != IDLE) begin
            base_q  <= pa[ADDR_WIDTH-1:OFS];
            is_fill <= (state_nx == FILL_REQ);
          end
          if (state_nx == SINGLE) begin
            mem_req   <= 1'b1;
            mem_we    <= write_through_req;
            mem_addr  <= pa;
            mem_wdata <= wt_data;
          end else if (state_nx == FILL_REQ) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {pa[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
          end
        end
        SINGLE, FILL_REQ, WB_REQ: begin
          if (bus_ack || bus_err || bus_tmo) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
          if (bus_ack && !mem_we) line_data <= mem_rdata;
          if (bus_ack && state == WB_REQ && !last_beat) cnt_q <= cnt_inc;
        end
        FILL_WR: begin
          if (!last_beat) begin
            cnt_q    <= cnt_inc;
            mem_req  <= 1'b1;
            mem_addr <= {base_q, cnt_inc};
          end
        end
        WB_RD: begin
          // SRAM data for addr_count is valid by the end of this cycle.
          mem_req   <= 1'b1;
          mem_we    <= 1'b1;
          mem_wdata <= wt_data;
          mem_addr  <= {base_q, cnt_q};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_biu.sv
// Directed testbench for l1_biu: a small bus responder plus one task per
// scenario, each with inline checks against hand-computed values.
`timescale 1ns/1ps
module tb_l1_biu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        read_req = 1'b0;
  logic        read_line_req = 1'b0;
  logic        write_through_req = 1'b0;
  logic        write_line_req = 1'b0;
  logic [23:0] pa = '0;
  logic [7:0]  wt_data;
  logic [7:0]  line_data;
  logic [7:0]  addr_count;
  logic        line_write;
  logic        cache_entry_refill;
  logic        trans_rdy;
  logic        bus_error;
  logic        mem_req;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        mem_err = 1'b0;

  int          total = 0;
  int          bad = 0;

  // responder / SRAM model configuration
  int          ack_wait = 0;
  bit          no_ack = 1'b0;
  bit          err_mode = 1'b0;
  bit          rdata_idx = 1'b0;
  bit          wb_model = 1'b0;
  logic [7:0]  rdata_fix = '0;
  logic [7:0]  wt_fix = '0;
  logic [7:0]  wb_word = '0;
  int          bus_cnt = 0;

  assign wt_data = wb_model ? wb_word : wt_fix;

  l1_biu #(
    .ADDR_WIDTH(24), .DATA_WIDTH(8), .LINE_BYTES(64), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .read_req(read_req), .read_line_req(read_line_req),
    .write_through_req(write_through_req), .write_line_req(write_line_req),
    .pa(pa), .wt_data(wt_data), .line_data(line_data), .addr_count(addr_count),
    .line_write(line_write), .cache_entry_refill(cache_entry_refill),
    .trans_rdy(trans_rdy), .bus_error(bus_error),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // Bus responder: ack (optionally with err) ack_wait cycles after the
  // zero-wait point, i.e. the cycle after mem_req rises when ack_wait=0.
  always @(posedge clk) begin
    #1;
    if (!rst_n || !mem_req) begin
      mem_ack = 1'b0;
      mem_err = 1'b0;
      bus_cnt = 0;
    end else if (!mem_ack && !mem_err) begin
      if (!no_ack && bus_cnt >= ack_wait + 1) begin
        mem_ack   = 1'b1;
        mem_err   = err_mode;
        mem_rdata = rdata_idx ? {2'b00, mem_addr[5:0]} : rdata_fix;
      end
      bus_cnt++;
    end
  end

  // L1 SRAM read model for writebacks: data word = addr_count ^ 0x5A.
  always @(posedge clk) begin
    #1;
    wb_word = addr_count ^ 8'h5A;
  end

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({mem_req, mem_we, line_write, trans_rdy, bus_error, cache_entry_refill} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {mem_req, mem_we, line_write, trans_rdy, bus_error, cache_entry_refill});
    end
    total++;
    if (addr_count !== 8'h00 || line_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_data: addr_count=%h line_data=%h want 00 00", addr_count, line_data);
    end
    total++;
    if (mem_addr !== 24'h0 || mem_wdata !== 8'h00) begin
      bad++;
      $display("FAIL reset_bus: mem_addr=%h mem_wdata=%h want 0 0", mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (mem_req !== 1'b0 || trans_rdy !== 1'b0) begin
      bad++;
      $display("FAIL idle_quiet: mem_req=%b trans_rdy=%b want 0 0", mem_req, trans_rdy);
    end
  endtask

  task automatic test_single_read;
    int cyc = 0;
    bit seen = 0;
    bit bus_bad = 0;
    ack_wait = 2; rdata_fix = 8'hA5; pa = 24'h123456;
    read_req = 1'b1;
    while (!seen && cyc < 50) begin
      @(negedge clk); cyc++;
      if (mem_req && (mem_addr !== 24'h123456 || mem_we !== 1'b0)) bus_bad = 1;
      if (trans_rdy) seen = 1;
    end
    read_req = 1'b0;
    total++;
    if (!seen) begin bad++; $display("FAIL read_done: no trans_rdy within %0d cycles", cyc); end
    total++;
    if (cyc != 5) begin bad++; $display("FAIL read_latency: got %0d want 5", cyc); end
    total++;
    if (line_data !== 8'hA5) begin bad++; $display("FAIL read_data: got %h want a5", line_data); end
    total++;
    if (bus_bad) begin bad++; $display("FAIL read_bus: addr/we wrong got addr=%h we=%b", mem_addr, mem_we); end
    @(negedge clk);
    total++;
    if (trans_rdy !== 1'b0 || line_data !== 8'hA5) begin
      bad++;
      $display("FAIL read_after: trans_rdy=%b line_data=%h want 0 a5", trans_rdy, line_data);
    end
  endtask

  task automatic test_single_write;
    int cyc = 0;
    bit seen = 0;
    bit bus_bad = 0;
    ack_wait = 0; wb_model = 0; wt_fix = 8'h3C; pa = 24'h00ABCD;
    write_through_req = 1'b1;
    while (!seen && cyc < 50) begin
      @(negedge clk); cyc++;
      wt_fix = 8'hFF;
      if (mem_req && (mem_addr !== 24'h00ABCD || mem_we !== 1'b1 || mem_wdata !== 8'h3C)) bus_bad = 1;
      if (trans_rdy) seen = 1;
    end
    write_through_req = 1'b0;
    total++;
    if (!seen || cyc != 3) begin bad++; $display("FAIL write_latency: got %0d seen=%0d want 3", cyc, seen); end
    total++;
    if (bus_bad) begin bad++; $display("FAIL write_bus: got addr=%h we=%b wdata=%h want 00abcd 1 3c", mem_addr, mem_we, mem_wdata); end
    total++;
    if (line_data !== 8'hA5) begin bad++; $display("FAIL write_hold: line_data=%h want a5", line_data); end
    @(negedge clk);
  endtask

  task automatic test_refill;
    int cyc = 0;
    int nb = 0;
    int refills = 0;
    bit seen = 0;
    bit beat_bad = 0;
    bit addr_bad = 0;
    ack_wait = 0; rdata_idx = 1; pa = 24'h0010C7;
    read_line_req = 1'b1;
    while (!seen && cyc < 400) begin
      @(negedge clk); cyc++;
      if (mem_req && mem_ack && mem_addr !== (24'h0010C0 | 24'(nb))) addr_bad = 1;
      if (line_write) begin
        if (addr_count !== 8'(nb) || line_data !== 8'(nb)) beat_bad = 1;
        nb++;
      end
      if (cache_entry_refill) refills++;
      if (trans_rdy) seen = 1;
    end
    read_line_req = 1'b0;
    rdata_idx = 0;
    total++;
    if (!seen || cyc != 193) begin bad++; $display("FAIL fill_latency: got %0d seen=%0d want 193", cyc, seen); end
    total++;
    if (nb != 64) begin bad++; $display("FAIL fill_beats: got %0d want 64", nb); end
    total++;
    if (beat_bad) begin bad++; $display("FAIL fill_data: addr_count/line_data differ from beat index"); end
    total++;
    if (addr_bad) begin bad++; $display("FAIL fill_addr: beat address not 0010c0+index, last %h", mem_addr); end
    total++;
    if (refills != 1 || cache_entry_refill !== 1'b1) begin
      bad++; $display("FAIL fill_refill_pulse: got %0d pulses want 1 with trans_rdy", refills);
    end
    @(negedge clk);
    total++;
    if (cache_entry_refill !== 1'b0 || trans_rdy !== 1'b0 || line_data !== 8'd63) begin
      bad++;
      $display("FAIL fill_after: refill=%b trans_rdy=%b line_data=%h want 0 0 3f",
               cache_entry_refill, trans_rdy, line_data);
    end
  endtask

  task automatic test_writeback;
    int cyc = 0;
    int nb = 0;
    bit seen = 0;
    bit beat_bad = 0;
    ack_wait = 0; wb_model = 1; pa = 24'h00A5F3;
    write_line_req = 1'b1;
    while (!seen && cyc < 400) begin
      @(negedge clk); cyc++;
      if (mem_req && mem_ack) begin
        if (mem_we !== 1'b1 || mem_wdata !== (8'(nb) ^ 8'h5A) || mem_addr !== (24'h00A5C0 | 24'(nb))) begin
          if (!beat_bad)
            $display("FAIL wb_beat: beat %0d got we=%b wdata=%h addr=%h want 1 %h %h",
                     nb, mem_we, mem_wdata, mem_addr, 8'(nb) ^ 8'h5A, 24'h00A5C0 | 24'(nb));
          beat_bad = 1;
        end
        nb++;
      end
      if (line_write) beat_bad = 1;
      if (trans_rdy) seen = 1;
    end
    write_line_req = 1'b0;
    wb_model = 0;
    total++;
    if (!seen || cyc != 193) begin bad++; $display("FAIL wb_latency: got %0d seen=%0d want 193", cyc, seen); end
    total++;
    if (nb != 64) begin bad++; $display("FAIL wb_beats: got %0d want 64", nb); end
    total++;
    if (beat_bad) bad++;
    total++;
    if (cache_entry_refill !== 1'b0) begin bad++; $display("FAIL wb_no_refill: got %b want 0", cache_entry_refill); end
    @(negedge clk);
  endtask

  task automatic test_wt_err;
    int cyc = 0;
    bit seen_err = 0;
    bit seen_rdy = 0;
    ack_wait = 0; err_mode = 1; wt_fix = 8'h81; pa = 24'h000777;
    write_through_req = 1'b1;
    while (!seen_err && cyc < 50) begin
      @(negedge clk); cyc++;
      if (trans_rdy) seen_rdy = 1;
      if (bus_error) seen_err = 1;
    end
    write_through_req = 1'b0;
    err_mode = 0;
    total++;
    if (!seen_err || cyc != 3) begin bad++; $display("FAIL err_pulse: got cyc=%0d seen=%0d want 3", cyc, seen_err); end
    total++;
    if (seen_rdy || mem_req !== 1'b0) begin bad++; $display("FAIL err_quiet: trans_rdy_seen=%0d mem_req=%b want 0 0", seen_rdy, mem_req); end
    @(negedge clk);
    total++;
    if (bus_error !== 1'b0 || trans_rdy !== 1'b0 || mem_req !== 1'b0) begin
      bad++; $display("FAIL err_idle: bus_error=%b trans_rdy=%b mem_req=%b want 0 0 0", bus_error, trans_rdy, mem_req);
    end
  endtask

  task automatic test_timeout;
    int cyc = 0;
    int rise = -1;
    bit seen = 0;
    bit seen_rdy = 0;
    no_ack = 1; pa = 24'h000010;
    read_req = 1'b1;
    while (!seen && cyc < 60) begin
      @(negedge clk); cyc++;
      if (mem_req && rise < 0) rise = cyc;
      if (trans_rdy) seen_rdy = 1;
      if (bus_error) seen = 1;
    end
    read_req = 1'b0;
    no_ack = 0;
    total++;
    if (!seen || rise < 0 || cyc - rise != 8) begin
      bad++; $display("FAIL tmo_delay: got %0d want 8 (seen=%0d)", cyc - rise, seen);
    end
    total++;
    if (seen_rdy || mem_req !== 1'b0) begin bad++; $display("FAIL tmo_quiet: trans_rdy_seen=%0d mem_req=%b want 0 0", seen_rdy, mem_req); end
    @(negedge clk);
  endtask

  task automatic test_priority;
    int cyc = 0;
    bit seen = 0;
    ack_wait = 0; wb_model = 1; rdata_fix = 8'h77; pa = 24'h00449B;
    write_line_req = 1'b1; read_req = 1'b1;
    while (!mem_req && cyc < 10) begin @(negedge clk); cyc++; end
    total++;
    if (mem_we !== 1'b1 || mem_addr !== 24'h004480) begin
      bad++; $display("FAIL prio_first: got we=%b addr=%h want 1 004480", mem_we, mem_addr);
    end
    cyc = 0;
    while (!seen && cyc < 400) begin @(negedge clk); cyc++; if (trans_rdy) seen = 1; end
    write_line_req = 1'b0;
    wb_model = 0;
    cyc = 0;
    while (!mem_req && cyc < 10) begin @(negedge clk); cyc++; end
    total++;
    if (mem_we !== 1'b0 || mem_addr !== 24'h00449B) begin
      bad++; $display("FAIL prio_second: got we=%b addr=%h want 0 00449b", mem_we, mem_addr);
    end
    seen = 0; cyc = 0;
    while (!seen && cyc < 50) begin @(negedge clk); cyc++; if (trans_rdy) seen = 1; end
    read_req = 1'b0;
    total++;
    if (!seen || line_data !== 8'h77) begin bad++; $display("FAIL prio_read_data: got %h seen=%0d want 77", line_data, seen); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_refill;
    int cyc = 0;
    bit stray = 0;
    ack_wait = 0; rdata_idx = 1; pa = 24'h0010C7;
    read_line_req = 1'b1;
    while (!(mem_req && addr_count == 8'd5) && cyc < 100) begin @(negedge clk); cyc++; end
    total++;
    if (addr_count !== 8'd5 || mem_req !== 1'b1) begin bad++; $display("FAIL mid_reach: addr_count=%h mem_req=%b want 05 1", addr_count, mem_req); end
    rst_n = 1'b0;
    read_line_req = 1'b0;
    #1;
    total++;
    if (mem_req !== 1'b0 || line_write !== 1'b0 || addr_count !== 8'h00 || trans_rdy !== 1'b0) begin
      bad++; $display("FAIL mid_reset: mem_req=%b line_write=%b addr_count=%h trans_rdy=%b want 0 0 00 0",
                      mem_req, line_write, addr_count, trans_rdy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rdata_idx = 0;
    repeat (10) begin
      @(negedge clk);
      if (trans_rdy || cache_entry_refill || mem_req || line_write) stray = 1;
    end
    total++;
    if (stray) begin bad++; $display("FAIL mid_after: activity after reset, got 1 want 0"); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_refill();
    test_writeback();
    test_wt_err();
    test_timeout();
    test_priority();
    test_reset_mid_refill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
